// File: rtl/clock_ctrl_pkg.sv
// clock_ctrl_pkg: shared types and constants for the crypto clock-select control stage.
package clock_ctrl_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_QUIESCE, ST_APPLY, ST_SETTLE} state_t;
    localparam logic [7:0] REG_ADDR    = 8'h2A;
    localparam int         BUSY_BIT    = 6;
    localparam int         PENDING_BIT = 5;
    localparam int         REG_W       = 5;
endpackage

// File: rtl/dip_debounce.sv
// dip_debounce: two-flop synchroniser followed by a stability counter for one DIP switch.
module dip_debounce #(
    parameter int pDEBOUNCE_CYCLES = 1000
) (
    input  logic usb_clk,
    input  logic reset,
    input  logic raw,
    output logic stable
);
    localparam int CW = $clog2(pDEBOUNCE_CYCLES);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    always_ff @(posedge usb_clk or posedge reset) begin
        if (reset) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == stable)
                cnt <= '0;
            else if (cnt == CW'(pDEBOUNCE_CYCLES - 1)) begin
                stable <= sync[1];
                cnt    <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/clock_select_ctrl.sv
// clock_select_ctrl: owns the crypto clock-select register and DIP selects, applying any
// change only while the crypto core is held in reset (quiesce -> apply -> settle).
module clock_select_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter logic [7:0] pREG_ADDR        = REG_ADDR,
    parameter int         pQUIESCE_CYCLES  = 8,
    parameter int         pSETTLE_CYCLES   = 64,
    parameter int         pDEBOUNCE_CYCLES = 1000
) (
    input  logic             usb_clk,
    input  logic             reset,
    input  logic [7:0]       I_addr,
    input  logic             I_wr,
    input  logic             I_rd,
    input  logic [7:0]       I_wdata,
    output logic [7:0]       O_rdata,
    output logic             O_rdata_valid,
    input  logic             I_j16_raw,
    input  logic             I_k16_raw,
    output logic [REG_W-1:0] O_clock_reg,
    output logic             O_j16_sel,
    output logic             O_k16_sel,
    output logic             O_crypto_rst,
    output logic             O_busy
);
    localparam int MAXC = (pQUIESCE_CYCLES > pSETTLE_CYCLES) ? pQUIESCE_CYCLES : pSETTLE_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    logic [REG_W-1:0] target;
    logic             j16_stable, k16_stable;
    logic             hit, mismatch;
    logic [7:0]       rword;
    logic             unused_wdata;
    state_t           state;
    logic [CW-1:0]    cnt;

    dip_debounce #(.pDEBOUNCE_CYCLES(pDEBOUNCE_CYCLES)) u_j16 (
        .usb_clk(usb_clk), .reset(reset), .raw(I_j16_raw), .stable(j16_stable)
    );
    dip_debounce #(.pDEBOUNCE_CYCLES(pDEBOUNCE_CYCLES)) u_k16 (
        .usb_clk(usb_clk), .reset(reset), .raw(I_k16_raw), .stable(k16_stable)
    );

    assign hit          = I_addr == pREG_ADDR;
    assign mismatch     = (target != O_clock_reg) | (j16_stable != O_j16_sel) | (k16_stable != O_k16_sel);
    assign unused_wdata = ^I_wdata[7:REG_W];

    always_comb begin
        rword              = '0;
        rword[BUSY_BIT]    = O_busy;
        rword[PENDING_BIT] = mismatch;
        rword[REG_W-1:0]   = O_clock_reg;
    end

    // Reads see pre-write state because target updates on the same edge the read samples.
    always_ff @(posedge usb_clk or posedge reset) begin
        if (reset) begin
            target        <= '0;
            O_rdata       <= '0;
            O_rdata_valid <= 1'b0;
        end else begin
            if (I_wr && hit)
                target <= I_wdata[REG_W-1:0];
            O_rdata_valid <= I_rd && hit;
            if (I_rd && hit)
                O_rdata <= rword;
        end
    end

    always_ff @(posedge usb_clk or posedge reset) begin
        if (reset) begin
            state        <= ST_SETTLE;
            cnt          <= '0;
            O_clock_reg  <= '0;
            O_j16_sel    <= 1'b0;
            O_k16_sel    <= 1'b0;
            O_crypto_rst <= 1'b1;
            O_busy       <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: if (mismatch) begin
                    state        <= ST_QUIESCE;
                    cnt          <= '0;
                    O_crypto_rst <= 1'b1;
                    O_busy       <= 1'b1;
                end
                ST_QUIESCE: if (cnt == CW'(pQUIESCE_CYCLES - 1)) state <= ST_APPLY;
                            else cnt <= cnt + 1'b1;
                ST_APPLY: begin
                    state       <= ST_SETTLE;
                    cnt         <= '0;
                    O_clock_reg <= target;
                    O_j16_sel   <= j16_stable;
                    O_k16_sel   <= k16_stable;
                end
                ST_SETTLE: if (cnt == CW'(pSETTLE_CYCLES - 1)) begin
                    cnt <= '0;
                    // A change that arrived mid-sequence chains straight into a new quiesce.
                    if (mismatch)
                        state <= ST_QUIESCE;
                    else begin
                        state        <= ST_IDLE;
                        O_crypto_rst <= 1'b0;
                        O_busy       <= 1'b0;
                    end
                end else
                    cnt <= cnt + 1'b1;
                default: state <= ST_SETTLE;
            endcase
        end
    end
endmodule

// File: tb/tb_clock_select_ctrl.sv
// tb_clock_select_ctrl: directed stimulus with a time-stamped expected-event scoreboard.
module tb_clock_select_ctrl;
    localparam int EV_RST = 0, EV_CREG = 1, EV_J16 = 2, EV_K16 = 3, EV_READ = 4;

    typedef struct {
        int kind;
        int at;
        int val;
    } ev_t;

    logic       usb_clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] I_addr = 8'h00;
    logic       I_wr = 1'b0, I_rd = 1'b0;
    logic [7:0] I_wdata = 8'h00;
    logic       I_j16_raw = 1'b0, I_k16_raw = 1'b0;
    logic [7:0] O_rdata;
    logic       O_rdata_valid;
    logic [4:0] O_clock_reg;
    logic       O_j16_sel, O_k16_sel, O_crypto_rst, O_busy;

    clock_select_ctrl dut (
        .usb_clk(usb_clk), .reset(reset), .I_addr(I_addr), .I_wr(I_wr), .I_rd(I_rd),
        .I_wdata(I_wdata), .O_rdata(O_rdata), .O_rdata_valid(O_rdata_valid),
        .I_j16_raw(I_j16_raw), .I_k16_raw(I_k16_raw), .O_clock_reg(O_clock_reg),
        .O_j16_sel(O_j16_sel), .O_k16_sel(O_k16_sel), .O_crypto_rst(O_crypto_rst),
        .O_busy(O_busy)
    );

    always #5 usb_clk = ~usb_clk;

    int cyc = 0;
    always @(posedge usb_clk) cyc <= cyc + 1;

    ev_t exp_q[$];
    int  errors = 0, checks = 0;
    bit  mon_en = 1'b0;
    logic [4:0] p_creg = '0;
    logic       p_rst = 1'b1, p_busy = 1'b1, p_j = 1'b0, p_k = 1'b0;

    function automatic string kname(int k);
        case (k)
            EV_RST:  return "rst_busy";
            EV_CREG: return "clock_reg";
            EV_J16:  return "j16_sel";
            EV_K16:  return "k16_sel";
            default: return "read";
        endcase
    endfunction

    task automatic expect_ev(int k, int at, int v);
        ev_t e;
        e.kind = k;
        e.at   = at;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic got(int k, int v);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected %s: got 0x%0h at cyc %0d, required no event", kname(k), v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.at != cyc || e.val != v) begin
                errors++;
                $display("FAIL %s: got %s=0x%0h at cyc %0d, required %s=0x%0h at cyc %0d",
                         kname(e.kind), kname(k), v, cyc, kname(e.kind), e.val, e.at);
            end
        end
    endtask

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: turns every output change into an event and scores it against the queue head.
    always @(negedge usb_clk) begin
        if (mon_en) begin
            if (O_crypto_rst !== p_rst || O_busy !== p_busy) got(EV_RST, int'({O_busy, O_crypto_rst}));
            if (O_clock_reg !== p_creg) got(EV_CREG, int'(O_clock_reg));
            if (O_j16_sel !== p_j) got(EV_J16, int'(O_j16_sel));
            if (O_k16_sel !== p_k) got(EV_K16, int'(O_k16_sel));
            if (O_rdata_valid) got(EV_READ, int'(O_rdata));
        end
        p_rst  = O_crypto_rst;
        p_busy = O_busy;
        p_creg = O_clock_reg;
        p_j    = O_j16_sel;
        p_k    = O_k16_sel;
    end

    task automatic at_neg(int c);
        while (cyc < c) @(negedge usb_clk);
    endtask

    // Bus access sampled by the DUT at edge t.
    task automatic bus(int t, bit wr, bit rd, logic [7:0] a, logic [7:0] d);
        at_neg(t - 1);
        I_wr    = wr;
        I_rd    = rd;
        I_addr  = a;
        I_wdata = d;
        @(negedge usb_clk);
        I_wr = 1'b0;
        I_rd = 1'b0;
    endtask

    initial begin
        int t, t2, r, c;
        repeat (3) @(negedge usb_clk);
        chk("rst_clock_reg", O_clock_reg, 0);
        chk("rst_j16", O_j16_sel, 0);
        chk("rst_k16", O_k16_sel, 0);
        chk("rst_rdata", O_rdata, 0);
        chk("rst_rdata_valid", O_rdata_valid, 0);
        chk("rst_crypto_rst", O_crypto_rst, 1);
        chk("rst_busy", O_busy, 1);
        mon_en = 1'b1;
        reset  = 1'b0;
        r = cyc;
        expect_ev(EV_RST, r + 64, 0);
        at_neg(r + 80);
        chk("idle_clock_reg", O_clock_reg, 0);
        chk("idle_busy", O_busy, 0);

        t = cyc + 2;
        expect_ev(EV_RST, t + 1, 3);
        expect_ev(EV_CREG, t + 10, 5);
        expect_ev(EV_RST, t + 74, 0);
        bus(t, 1, 0, 8'h2A, 8'h05);
        at_neg(t + 80);

        t = cyc + 2;
        expect_ev(EV_RST, t + 1, 3);
        expect_ev(EV_CREG, t + 10, 5'h01);
        expect_ev(EV_CREG, t + 83, 5'h11);
        expect_ev(EV_RST, t + 147, 0);
        bus(t, 1, 0, 8'h2A, 8'hE1);
        bus(t + 20, 1, 0, 8'h2A, 8'h09);
        bus(t + 30, 1, 0, 8'h2A, 8'h11);
        at_neg(t + 155);

        t = cyc + 2;
        expect_ev(EV_READ, t + 3, 8'h11);
        bus(t, 1, 0, 8'h2A, 8'h11);
        bus(t + 3, 0, 1, 8'h2A, 8'h00);
        t2 = t + 6;
        expect_ev(EV_READ, t2, 8'h11);
        expect_ev(EV_RST, t2 + 1, 3);
        expect_ev(EV_READ, t2 + 1, 8'h31);
        expect_ev(EV_READ, t2 + 2, 8'h71);
        expect_ev(EV_CREG, t2 + 10, 5'h0A);
        expect_ev(EV_RST, t2 + 74, 0);
        bus(t2, 1, 1, 8'h2A, 8'h0A);
        bus(t2 + 1, 0, 1, 8'h2A, 8'h00);
        bus(t2 + 2, 0, 1, 8'h2A, 8'h00);
        bus(t2 + 3, 1, 1, 8'h2B, 8'h1F);
        at_neg(t2 + 80);

        c = cyc;
        I_j16_raw = 1'b1;
        at_neg(c + 500);
        I_j16_raw = 1'b0;
        at_neg(c + 520);

        c = cyc;
        expect_ev(EV_RST, c + 1003, 3);
        expect_ev(EV_J16, c + 1012, 1);
        expect_ev(EV_K16, c + 1012, 1);
        expect_ev(EV_RST, c + 1076, 0);
        I_j16_raw = 1'b1;
        I_k16_raw = 1'b1;
        at_neg(c + 1100);
        c = cyc;
        expect_ev(EV_RST, c + 1003, 3);
        expect_ev(EV_J16, c + 1012, 0);
        expect_ev(EV_K16, c + 1012, 0);
        expect_ev(EV_RST, c + 1076, 0);
        I_j16_raw = 1'b0;
        I_k16_raw = 1'b0;
        at_neg(c + 1100);

        t = cyc + 2;
        expect_ev(EV_RST, t + 1, 3);
        expect_ev(EV_CREG, t + 10, 5);
        expect_ev(EV_CREG, t + 31, 0);
        bus(t, 1, 0, 8'h2A, 8'h05);
        at_neg(t + 30);
        #2 reset = 1'b1;
        repeat (3) @(negedge usb_clk);
        chk("midrst_clock_reg", O_clock_reg, 0);
        chk("midrst_crypto_rst", O_crypto_rst, 1);
        chk("midrst_busy", O_busy, 1);
        chk("midrst_rdata", O_rdata, 0);
        chk("midrst_rdata_valid", O_rdata_valid, 0);
        reset = 1'b0;
        r = cyc;
        expect_ev(EV_RST, r + 64, 0);
        at_neg(r + 100);

        t = cyc + 2;
        expect_ev(EV_READ, t + 1, 8'h00);
        bus(t, 1, 0, 8'h2A, 8'h00);
        bus(t + 1, 0, 1, 8'h2A, 8'h00);
        at_neg(t + 20);
        chk("final_busy", O_busy, 0);
        chk("events_outstanding", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/clock_select_ctrl.md
# clock_select_ctrl

Control stage directly upstream of the crypto clock mux/output block, in the `usb_clk` domain. It owns the 5-bit clock-select register written over the USB register bus. It synchronises and debounces the J16/K16 DIP switches. Any change of clock selection runs through a quiesce/apply/settle sequence that holds the crypto core in reset, so the clock mux never switches under active logic.

## Interface
Parameters:
- `pREG_ADDR`, 8'h2A: register bus address of the clock-select register.
- `pQUIESCE_CYCLES`, 8: cycles `O_crypto_rst` is high before the selection changes (≥1).
- `pSETTLE_CYCLES`, 64: cycles `O_crypto_rst` stays high after the selection changes (≥1).
- `pDEBOUNCE_CYCLES`, 1000: cycles a synchronised DIP level must be stable before it is accepted (≥2).

Ports:
- `usb_clk`  in  1  sole clock.
- `reset`  in  1  asynchronous, active-high reset.
- `I_addr`  in  8  register address.
- `I_wr`  in  1  single-cycle write strobe.
- `I_rd`  in  1  single-cycle read strobe.
- `I_wdata`  in  8  write data; bits [7:5] ignored.
- `O_rdata`  out  8  read data.
- `O_rdata_valid`  out  1  read data qualifier.
- `I_j16_raw`  in  1  asynchronous DIP input (source select).
- `I_k16_raw`  in  1  asynchronous DIP input (output enable).
- `O_clock_reg`  out  5  applied clock-select register, feeds the clock block.
- `O_j16_sel`  out  1  applied debounced J16.
- `O_k16_sel`  out  1  applied debounced K16.
- `O_crypto_rst`  out  1  crypto-domain reset request.
- `O_busy`  out  1  switch sequence in progress.

## Operation
- Reset values: `O_clock_reg`=0, `O_j16_sel`=0, `O_k16_sel`=0, `O_rdata`=0, `O_rdata_valid`=0, `O_crypto_rst`=1, `O_busy`=1. The FSM resets into SETTLE.
- `target` register (5b, reset 0) loads `I_wdata[4:0]` on every `I_wr` with `I_addr==pREG_ADDR`, in any state.
- Debounce, per DIP: 2-FF synchroniser, then a counter. The counter increments while the synchronised level differs from the stable value and clears when they are equal. At `pDEBOUNCE_CYCLES-1` the stable value flips and the counter clears. Stable value resets to 0.
- `mismatch` = (`target`≠`O_clock_reg`) | (stable J16≠`O_j16_sel`) | (stable K16≠`O_k16_sel`).
- FSM states:
  - IDLE: `O_busy`=0, `O_crypto_rst`=0. Goes to QUIESCE when `mismatch`.
  - QUIESCE: `O_crypto_rst`=1. Lasts `pQUIESCE_CYCLES`, then goes to APPLY.
  - APPLY: 1 cycle. Loads `O_clock_reg`←`target` and the DIP outputs←stable values, using values present at the start of the cycle. Goes to SETTLE.
  - SETTLE: `O_crypto_rst`=1. Lasts `pSETTLE_CYCLES`. Then goes to QUIESCE if `mismatch` (`O_crypto_rst` stays high), else to IDLE.
- In all states except IDLE: `O_busy`=1 and `O_crypto_rst`=1.
- A write equal to `O_clock_reg` while in IDLE starts no sequence.
- Multiple writes during a sequence: the last one wins. It is applied by the following sequence.
- Read: if `I_rd` and `I_addr==pREG_ADDR`, then next cycle `O_rdata_valid`=1 and `O_rdata`={1'b0, `O_busy`, `mismatch`, `O_clock_reg`}. A non-matching read gives `O_rdata_valid`=0. Otherwise `O_rdata_valid`=0 and `O_rdata` holds its last value.
- Read and write in the same cycle: the read returns the pre-write state.
- Reset asserted mid-sequence: all outputs return to their reset values immediately; `target` clears to 0.

## Timing
- Write sampled at edge T, in IDLE with a new value:
  - `O_busy` and `O_crypto_rst` rise at T+1.
  - New `O_clock_reg` visible at T+2+`pQUIESCE_CYCLES`.
  - `O_busy` and `O_crypto_rst` fall at T+2+`pQUIESCE_CYCLES`+`pSETTLE_CYCLES`.
  - Defaults: T+10 and T+74.
- After reset release: `O_crypto_rst` falls `pSETTLE_CYCLES` edges after the first edge with `reset` low.
- DIP path: raw change to stable-value change takes 2 + `pDEBOUNCE_CYCLES` cycles. The sequence then starts 1 cycle later, with the same timing as a write.
- Read latency: 1 cycle.

## Structure
- Package `clock_ctrl_pkg` holds:
  - FSM state enum (IDLE, QUIESCE, APPLY, SETTLE).
  - `pREG_ADDR` default.
  - Read-word bit positions: BUSY=6, PENDING=5, REG=[4:0].
- Sub-module `dip_debounce` (synchroniser + counter, parameter `pDEBOUNCE_CYCLES`), instantiated twice.
- Shared counter width: $clog2 of the larger of `pQUIESCE_CYCLES` and `pSETTLE_CYCLES`.

## Test plan
- Release reset, no activity -> `O_crypto_rst` high for exactly 64 cycles, then low. `O_clock_reg`=0, `O_busy`=0.
- Write 0x05 at T -> `O_busy`/`O_crypto_rst` high at T+1. `O_clock_reg`=5'b00101 at T+10. `O_crypto_rst` low at T+74.
- Write 0x01 at T, 0x09 at T+20, 0x11 at T+30 -> first sequence applies 0x01. A second sequence follows with no `O_crypto_rst` gap and applies 0x11; 0x09 is never applied.
- Write 0x00 while `O_clock_reg`=0 in IDLE -> `O_busy` stays 0. Read returns `O_rdata`=0x00 one cycle later with valid.
- Glitch `I_j16_raw` high for 500 cycles -> no change. Hold it high for 1100 cycles -> `O_j16_sel`=1 after the sequence, with `O_crypto_rst` pulsed.
- Assert `reset` during SETTLE of a 0x05 write -> outputs return to reset values. `target`=0, so no sequence re-runs after the post-reset settle.
